mode4_tree_sequencer: RTL and testbench
=======================================

Name: mode4_tree_sequencer

Overview:
- Upstream feeder and controller for mode4_adder_tree.
- Accepts a vector of VECTOR_DEPTH elements as a valid/ready stream of 4-lane beats, and registers each beat onto the tree's inp0..inp3.
- Generates the tree's three stage-run enables so that every beat passes each tree stage exactly once.
- After the last beat drains, captures the accumulated tree output, presents it on a valid/ready result port, then clears the tree for the next vector.

Parameters:
DATA_WIDTH, 16, element width (matches tree DATAWIDTH)
VECTOR_DEPTH, 64, elements per vector; must be a multiple of 4 and >= 4
BEATS, VECTOR_DEPTH/4, derived local parameter; 4-lane beats per vector
CNT_W, clog2(BEATS) (min 1), derived local parameter; beat counter width

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid && in_ready
in_data  in  4*DATA_WIDTH  lane k = in_data[k*DATA_WIDTH +: DATA_WIDTH]
inp0..inp3  out  DATA_WIDTH each  registered lanes 0..3 to tree
mode4_stage2_run  out  1  tree stage2 enable
mode4_stage1_run  out  1  tree stage1 enable
mode4_stage0_run  out  1  tree accumulate enable
tree_clr  out  1  active-high clear; connects to tree reset
sum_in  in  DATA_WIDTH  tree outp
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid && out_ready
out_data  out  DATA_WIDTH  registered vector sum

Behaviour:
- Reset (reset=0, async) values:
  - state=CLEAR; beat count=0; v2/v1/v0=0
  - inp0..3=0, out_data=0, out_valid=0, in_ready=0
  - all run enables=0
  - tree_clr=1
- States:
  - CLEAR: tree_clr=1 for exactly one cycle, then go to FILL.
  - FILL:
    - in_ready=1; in_ready depends on state only, never on in_valid.
    - On accept: load inp0..3 from in_data, set v2=1, increment count.
    - On the accept where count==BEATS-1: reset count to 0, go to DRAIN.
    - Cycles with no accept set v2=0 (bubble).
  - DRAIN:
    - in_ready=0.
    - When v2|v1|v0==0: capture out_data<=sum_in, set out_valid=1, go to RESULT.
  - RESULT:
    - out_valid=1; out_data held stable.
    - On out_ready: clear out_valid, go to CLEAR.
- Run enables:
  - mode4_stage2_run=v2, mode4_stage1_run=v1, mode4_stage0_run=v0, all registered.
  - Every cycle v1<=v2 and v0<=v1.
  - Bubbles propagate, so no stage register is ever consumed twice.
- Timing:
  - Beat accepted at edge E0: stage2_run high in cycle after E0, stage1_run one cycle later, stage0_run two cycles later.
  - Tree outp includes the beat after E3.
  - out_valid rises at E4 after the last accept: latency 4 cycles.
- Throughput:
  - One beat per cycle in FILL.
  - Per-vector overhead: 4 (drain) + >=1 (result) + 1 (clear) cycles.
- No arithmetic is done here. Data passes through unmodified; out_data is a bit-exact copy of sum_in.
- Boundary conditions:
  - in_valid outside FILL: ignored, no state change.
  - BEATS=1: the first accept is the last.
  - out_ready held high: RESULT lasts exactly one cycle.
  - out_ready low: stall indefinitely; no run pulses, no tree_clr.
  - Reset mid-operation: immediate return to reset values. tree_clr=1 throughout reset and for the first cycle after release, so no partial sum survives.
  - Count wraps only via the last-beat transition, never by overflow.

Decomposition:
- Shared package holds DATA_WIDTH, VECTOR_DEPTH and the LANES=4 constant.
- State encoding (CLEAR, FILL, DRAIN, RESULT) is a localparam set in the package.
- No sub-module. The valid shift chain and FSM are small enough to inline.
- Bench top instantiates mode4_tree_sequencer plus mode4_adder_tree, with tree reset=tree_clr and sum_in=outp.

Test Plan:
1. Reset held low 5 cycles, then released -> tree_clr=1 during reset and for 1 cycle after; in_ready=0 then 1; out_valid=0; all run enables=0.
2. 16 back-to-back beats, each lane =0x0001 -> stage2_run high 16 consecutive cycles, stage1 shifted +1, stage0 shifted +2; out_valid 4 cycles after last accept; out_data=0x0040.
3. in_valid toggling 1/0 each cycle, lanes = beat index (0..15) -> exactly 16 pulses on each run enable with matching bubbles; out_data=0x01E0 (4*sum 0..15).
4. out_ready low 10 cycles at result -> out_valid and out_data stable, in_ready=0, no run or tree_clr pulses; then out_ready=1 -> one-cycle tree_clr, next vector of 0x0002 lanes gives 0x0080 with no carryover.
5. Reset asserted asynchronously mid-cycle after 7 beats -> outputs take reset values immediately; after release, a full vector of 0x0001 gives 0x0040.
6. VECTOR_DEPTH=4 build, single beat lanes 1,2,3,4 -> DRAIN entered on first accept; out_valid 4 cycles later; out_data=0x000A.

Source files
------------

// File: rtl/mode4_tree_sequencer_pkg.sv
// rtl/mode4_tree_sequencer_pkg.sv - shared constants and state encoding for the adder-tree sequencer
package mode4_tree_sequencer_pkg;

    localparam int DATA_WIDTH_DEFAULT   = 16;
    localparam int VECTOR_DEPTH_DEFAULT = 64;
    localparam int LANES                = 4;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_FILL   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

endpackage

// File: rtl/mode4_tree_sequencer_if.sv
// rtl/mode4_tree_sequencer_if.sv - beat input stream and result output stream of the sequencer
interface mode4_tree_sequencer_if
    import mode4_tree_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
);
    logic                        in_valid;
    logic                        in_ready;
    logic [LANES*DATA_WIDTH-1:0] in_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_WIDTH-1:0]       out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/mode4_tree_sequencer.sv
// rtl/mode4_tree_sequencer.sv - feeds 4-lane beats into mode4_adder_tree and returns the vector sum
module mode4_tree_sequencer
    import mode4_tree_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEFAULT,
    parameter int VECTOR_DEPTH = VECTOR_DEPTH_DEFAULT
)(
    input  logic                  clk,
    input  logic                  reset,
    mode4_tree_sequencer_if.slave bus,
    output logic [DATA_WIDTH-1:0] inp0,
    output logic [DATA_WIDTH-1:0] inp1,
    output logic [DATA_WIDTH-1:0] inp2,
    output logic [DATA_WIDTH-1:0] inp3,
    output logic                  mode4_stage2_run,
    output logic                  mode4_stage1_run,
    output logic                  mode4_stage0_run,
    output logic                  tree_clr,
    input  logic [DATA_WIDTH-1:0] sum_in
);

    localparam int BEATS = VECTOR_DEPTH / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  v2, v1, v0;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  accept;

    assign accept        = bus.in_valid && in_ready_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    assign mode4_stage2_run = v2;
    assign mode4_stage1_run = v1;
    assign mode4_stage0_run = v0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_CLEAR;
            cnt         <= '0;
            v2          <= 1'b0;
            v1          <= 1'b0;
            v0          <= 1'b0;
            inp0        <= '0;
            inp1        <= '0;
            inp2        <= '0;
            inp3        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            tree_clr    <= 1'b1;
        end else begin
            // Valid chain always shifts; a cycle without an accept inserts a bubble.
            v2 <= 1'b0;
            v1 <= v2;
            v0 <= v1;
            case (state)
                ST_CLEAR: begin
                    tree_clr   <= 1'b0;
                    in_ready_q <= 1'b1;
                    state      <= ST_FILL;
                end
                ST_FILL: begin
                    if (accept) begin
                        inp0 <= bus.in_data[0*DATA_WIDTH +: DATA_WIDTH];
                        inp1 <= bus.in_data[1*DATA_WIDTH +: DATA_WIDTH];
                        inp2 <= bus.in_data[2*DATA_WIDTH +: DATA_WIDTH];
                        inp3 <= bus.in_data[3*DATA_WIDTH +: DATA_WIDTH];
                        v2   <= 1'b1;
                        if (cnt == LAST_BEAT) begin
                            cnt        <= '0;
                            in_ready_q <= 1'b0;
                            state      <= ST_DRAIN;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Once the chain is empty the tree output holds the final sum.
                    if (!(v2 || v1 || v0)) begin
                        out_data_q  <= sum_in;
                        out_valid_q <= 1'b1;
                        state       <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        tree_clr    <= 1'b1;
                        state       <= ST_CLEAR;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_mode4_tree_sequencer.sv
// tb/tb_mode4_tree_sequencer.sv - self-checking bench for mode4_tree_sequencer with a behavioural adder tree
`timescale 1ns/1ps
module tb_mode4_tree_sequencer;
    import mode4_tree_sequencer_pkg::*;

    localparam int DW      = 16;
    localparam int BEATS_A = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mode4_tree_sequencer_if #(.DATA_WIDTH(DW)) a_if ();
    mode4_tree_sequencer_if #(.DATA_WIDTH(DW)) b_if ();

    logic [DW-1:0] a_inp0, a_inp1, a_inp2, a_inp3, a_sum;
    logic          a_r2, a_r1, a_r0, a_clr;
    logic [DW-1:0] b_inp0, b_inp1, b_inp2, b_inp3, b_sum;
    logic          b_r2, b_r1, b_r0, b_clr;

    mode4_tree_sequencer #(.DATA_WIDTH(DW), .VECTOR_DEPTH(64)) dut_a (
        .clk(clk), .reset(reset), .bus(a_if),
        .inp0(a_inp0), .inp1(a_inp1), .inp2(a_inp2), .inp3(a_inp3),
        .mode4_stage2_run(a_r2), .mode4_stage1_run(a_r1), .mode4_stage0_run(a_r0),
        .tree_clr(a_clr), .sum_in(a_sum)
    );

    mode4_tree_sequencer #(.DATA_WIDTH(DW), .VECTOR_DEPTH(4)) dut_b (
        .clk(clk), .reset(reset), .bus(b_if),
        .inp0(b_inp0), .inp1(b_inp1), .inp2(b_inp2), .inp3(b_inp3),
        .mode4_stage2_run(b_r2), .mode4_stage1_run(b_r1), .mode4_stage0_run(b_r0),
        .tree_clr(b_clr), .sum_in(b_sum)
    );

    // Behavioural mode4_adder_tree: pair adds, final add, accumulator; tree_clr clears it.
    logic [DW-1:0] at2a, at2b, at1, atacc, bt2a, bt2b, bt1, btacc;
    always @(posedge clk or posedge a_clr) begin
        if (a_clr) begin
            at2a <= '0; at2b <= '0; at1 <= '0; atacc <= '0;
        end else begin
            if (a_r2) begin at2a <= a_inp0 + a_inp1; at2b <= a_inp2 + a_inp3; end
            if (a_r1) at1 <= at2a + at2b;
            if (a_r0) atacc <= atacc + at1;
        end
    end
    assign a_sum = atacc;

    always @(posedge clk or posedge b_clr) begin
        if (b_clr) begin
            bt2a <= '0; bt2b <= '0; bt1 <= '0; btacc <= '0;
        end else begin
            if (b_r2) begin bt2a <= b_inp0 + b_inp1; bt2b <= b_inp2 + b_inp3; end
            if (b_r1) bt1 <= bt2a + bt2b;
            if (b_r0) btacc <= btacc + bt1;
        end
    end
    assign b_sum = btacc;

    // Edge numbers of accepts and cycles in which each run enable is high.
    int acc_q[$];
    int s2_q[$];
    int s1_q[$];
    int s0_q[$];
    always @(negedge clk) begin
        if (a_if.in_valid && a_if.in_ready) acc_q.push_back(cyc + 1);
        if (a_r2) s2_q.push_back(cyc);
        if (a_r1) s1_q.push_back(cyc);
        if (a_r0) s0_q.push_back(cyc);
    end

    logic [DW-1:0] last_lane0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_vector(input int dmode, input int vmode, input logic [DW-1:0] cval,
                               input int nbeats, output logic [DW-1:0] exp_sum);
        int sent;
        int guard;
        logic go;
        logic [DW-1:0] ln [4];
        sent    = 0;
        guard   = 0;
        exp_sum = '0;
        @(posedge clk); #1;
        acc_q.delete(); s2_q.delete(); s1_q.delete(); s0_q.delete();
        while (sent < nbeats && guard < 400) begin
            case (vmode)
                0:       go = 1'b1;
                1:       go = (guard % 2 == 0);
                default: go = ($urandom_range(0, 3) != 0);
            endcase
            for (int k = 0; k < 4; k++) begin
                case (dmode)
                    0:       ln[k] = cval;
                    1:       ln[k] = DW'(sent);
                    default: ln[k] = DW'($urandom);
                endcase
            end
            a_if.in_valid = go;
            a_if.in_data  = {ln[3], ln[2], ln[1], ln[0]};
            if (go && a_if.in_ready) begin
                exp_sum    = exp_sum + ln[0] + ln[1] + ln[2] + ln[3];
                last_lane0 = ln[0];
                sent++;
            end
            @(posedge clk); #1;
            guard++;
        end
        a_if.in_valid = 1'b0;
        check("beats_sent", sent, nbeats);
    endtask

    task automatic check_pipe();
        int m;
        m = 0;
        check("n_accepts", acc_q.size(), BEATS_A);
        check("n_stage2", s2_q.size(), acc_q.size());
        check("n_stage1", s1_q.size(), acc_q.size());
        check("n_stage0", s0_q.size(), acc_q.size());
        for (int i = 0; i < acc_q.size(); i++) begin
            if (i >= s2_q.size() || s2_q[i] != acc_q[i])     m++;
            if (i >= s1_q.size() || s1_q[i] != acc_q[i] + 1) m++;
            if (i >= s0_q.size() || s0_q[i] != acc_q[i] + 2) m++;
        end
        check("pipe_align", m, 0);
    endtask

    task automatic finish_result(input logic [DW-1:0] exp, input int stall);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_if.out_valid && n < 80);
        check("result_seen", a_if.out_valid, 1);
        check("latency", cyc - acc_q[$], 4);
        check("out_data", a_if.out_data, exp);
        check_pipe();
        a_if.in_valid = 1'b1;
        a_if.in_data  = {4{16'hBEEF}};
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", a_if.out_valid, 1);
            check("stall_data", a_if.out_data, exp);
            check("stall_ready", a_if.in_ready, 0);
            check("stall_quiet", {a_r2, a_r1, a_r0, a_clr}, 0);
            check("stall_inp0", a_inp0, last_lane0);
        end
        a_if.in_valid  = 1'b0;
        a_if.out_ready = 1'b1;
        @(negedge clk);
        check("valid_drop", a_if.out_valid, 0);
        check("clr_pulse", a_clr, 1);
        a_if.out_ready = 1'b0;
        @(negedge clk);
        check("clr_single", a_clr, 0);
        check("ready_fill", a_if.in_ready, 1);
    endtask

    initial begin
        logic [DW-1:0] s;
        int e0;
        int n;
        a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.out_ready = 1'b0;
        b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.out_ready = 1'b0;

        // Reset held for 5 cycles, then released.
        repeat (5) @(posedge clk);
        #1;
        check("rst_clr", a_clr, 1);
        check("rst_ready", a_if.in_ready, 0);
        check("rst_valid", a_if.out_valid, 0);
        check("rst_runs", {a_r2, a_r1, a_r0}, 0);
        check("rst_inp", {a_inp0, a_inp1, a_inp2, a_inp3}, 0);
        check("rst_out", a_if.out_data, 0);
        check("rst_b_clr", b_clr, 1);
        reset = 1'b1;
        #1;
        check("rel_clr", a_clr, 1);
        @(posedge clk); #1;
        check("rel_clr_off", a_clr, 0);
        check("rel_ready", a_if.in_ready, 1);

        // Single-beat build: lanes 1,2,3,4.
        b_if.in_data  = {16'd4, 16'd3, 16'd2, 16'd1};
        b_if.in_valid = 1'b1;
        e0 = cyc + 1;
        @(posedge clk); #1;
        b_if.in_valid = 1'b0;
        check("b_drain", b_if.in_ready, 0);
        check("b_run2", b_r2, 1);
        n = 0;
        while (!b_if.out_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("b_latency", cyc - e0, 4);
        check("b_sum", b_if.out_data, 16'h000A);
        b_if.out_ready = 1'b1;
        @(posedge clk); #1;
        check("b_clr", b_clr, 1);
        check("b_valid_drop", b_if.out_valid, 0);
        b_if.out_ready = 1'b0;

        // Back-to-back ones.
        send_vector(0, 0, 16'h0001, BEATS_A, s);
        finish_result(s, 0);
        check("ones_sum", a_if.out_data, 16'h0040);

        // Toggling valid, lanes = beat index, 10-cycle result stall.
        send_vector(1, 1, 16'h0000, BEATS_A, s);
        finish_result(s, 10);
        check("index_sum", a_if.out_data, 16'h01E0);

        // Twos after a stalled result: no carryover.
        send_vector(0, 0, 16'h0002, BEATS_A, s);
        finish_result(s, 0);
        check("twos_sum", a_if.out_data, 16'h0080);

        // Asynchronous reset mid-cycle after 7 beats.
        send_vector(0, 0, 16'h0001, 7, s);
        #3 reset = 1'b0;
        #1;
        check("mid_rst_clr", a_clr, 1);
        check("mid_rst_ready", a_if.in_ready, 0);
        check("mid_rst_runs", {a_r2, a_r1, a_r0}, 0);
        check("mid_rst_inp0", a_inp0, 0);
        check("mid_rst_valid", a_if.out_valid, 0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rel_clr", a_clr, 1);
        @(posedge clk); #1;
        check("mid_rel_clr_off", a_clr, 0);
        send_vector(0, 0, 16'h0001, BEATS_A, s);
        finish_result(s, 0);
        check("post_rst_sum", a_if.out_data, 16'h0040);

        // Random data and random valid gaps; last one with out_ready held high.
        for (int v = 0; v < 3; v++) begin
            a_if.out_ready = (v == 2);
            send_vector(2, 2, 16'h0000, BEATS_A, s);
            finish_result(s, (v == 0) ? 3 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
